ram16_copier: RTL and testbench

- Bus initiator that drives the byte-addressed, 16-bit-word scratch RAM port to copy a block of words from a source address to a destination address.
- Sits between the CPU-side control registers and the RAM, and owns the RAM address, data, write and output-enable lines while busy.
- Copies one word per two clock cycles: a read cycle followed by a write cycle.
- Selects copy direction automatically, so overlapping regions copy correctly (memmove semantics).

---
 rtl/ram16_copier.sv | 150 +++++++++++++++
 tb/tb_ram16_copier.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram16_copier.sv
// ram16_copier: block copier for the 16-bit-word, byte-addressed scratch RAM.
// Moves one word every two cycles (read, then write). The copy direction is
// chosen at start so that overlapping source/destination ranges behave like
// memmove. While busy, this block owns the RAM address, data and strobes.
module ram16_copier #(
  parameter int addrSize  = 9,
  parameter int countSize = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [addrSize-1:0]  src_addr,
  input  logic [addrSize-1:0]  dst_addr,
  input  logic [countSize-1:0] word_count,
  output logic                 busy,
  output logic                 done,
  output logic [addrSize-1:0]  ram_addr,
  output logic [15:0]          ram_data_out,
  output logic                 ram_write_rq,
  output logic                 ram_output_en,
  input  logic [15:0]          ram_data_in
);

  localparam int CW = addrSize + 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                 state_reg;
  logic [addrSize-1:0]    src_ptr_reg;
  logic [addrSize-1:0]    dst_ptr_reg;
  logic [countSize-1:0]   remaining_reg;
  logic                   desc_reg;
  logic                   write_rq_reg;
  logic                   output_en_reg;

  // Start-time direction decision, done on unwrapped addresses so a range
  // that runs past the top of memory is still compared correctly.
  logic [CW-1:0]          src_wide;
  logic [CW-1:0]          dst_wide;
  logic [CW-1:0]          span_wide;
  logic [CW-1:0]          end_wide;
  logic                   start_desc;
  logic [countSize-1:0]   last_index;
  logic [addrSize-1:0]    last_offset;
  logic [addrSize-1:0]    start_src;
  logic [addrSize-1:0]    start_dst;
  logic [addrSize-1:0]    src_step;
  logic [addrSize-1:0]    dst_step;

  assign src_wide    = {1'b0, src_addr};
  assign dst_wide    = {1'b0, dst_addr};
  assign span_wide   = CW'({word_count, 1'b0});
  assign end_wide    = src_wide + span_wide;
  assign start_desc  = (dst_wide > src_wide) && (dst_wide < end_wide);

  // Descending copies begin at the last word of each block.
  assign last_index  = word_count - countSize'(1);
  assign last_offset = addrSize'({last_index, 1'b0});
  assign start_src   = start_desc ? src_addr + last_offset : src_addr;
  assign start_dst   = start_desc ? dst_addr + last_offset : dst_addr;

  // Pointer advance by one word; arithmetic wraps at the top of memory.
  assign src_step = desc_reg ? src_ptr_reg - addrSize'(2) : src_ptr_reg + addrSize'(2);
  assign dst_step = desc_reg ? dst_ptr_reg - addrSize'(2) : dst_ptr_reg + addrSize'(2);

  // Strobes are qualified by reset so an abort cancels a write that is
  // already on the bus instead of letting it land on the reset edge.
  assign ram_write_rq  = write_rq_reg  & reset;
  assign ram_output_en = output_en_reg & reset;

  // Copy sequencer: all bus outputs are set up one edge ahead of their cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      src_ptr_reg   <= '0;
      dst_ptr_reg   <= '0;
      remaining_reg <= '0;
      desc_reg      <= 1'b0;
      write_rq_reg  <= 1'b0;
      output_en_reg <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ram_addr      <= '0;
      ram_data_out  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          busy          <= 1'b0;
          done          <= 1'b0;
          write_rq_reg  <= 1'b0;
          output_en_reg <= 1'b0;
          ram_addr      <= '0;
          ram_data_out  <= '0;
          if (start) begin
            src_ptr_reg   <= start_src;
            dst_ptr_reg   <= start_dst;
            remaining_reg <= word_count;
            desc_reg      <= start_desc;
            busy          <= 1'b1;
            if (word_count == '0) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg     <= READ;
              ram_addr      <= start_src;
              output_en_reg <= 1'b1;
            end
          end
        end

        READ: begin
          // ram_data_out doubles as the holding register for the word in flight.
          ram_data_out  <= ram_data_in;
          ram_addr      <= dst_ptr_reg;
          output_en_reg <= 1'b0;
          write_rq_reg  <= 1'b1;
          state_reg     <= WRITE;
        end

        WRITE: begin
          src_ptr_reg   <= src_step;
          dst_ptr_reg   <= dst_step;
          remaining_reg <= remaining_reg - countSize'(1);
          write_rq_reg  <= 1'b0;
          ram_data_out  <= '0;
          if (remaining_reg > countSize'(1)) begin
            state_reg     <= READ;
            ram_addr      <= src_step;
            output_en_reg <= 1'b1;
          end else begin
            state_reg <= DONE;
            ram_addr  <= '0;
            done      <= 1'b1;
          end
        end

        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram16_copier.sv
// tb_ram16_copier: directed tests for ram16_copier with a byte-wide RAM model
// and a scoreboard. Driver code queues the expected bus transactions; the
// monitor pops and compares them as the DUT puts them on the bus.
module tb_ram16_copier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  src_addr;
  logic [8:0]  dst_addr;
  logic [7:0]  word_count;
  logic        busy;
  logic        done;
  logic [8:0]  ram_addr;
  logic [15:0] ram_data_out;
  logic        ram_write_rq;
  logic        ram_output_en;
  logic [15:0] ram_data_in;

  // Preload port into the RAM model, used only while the DUT is idle.
  logic        pl_en;
  logic [8:0]  pl_addr;
  logic [15:0] pl_data;

  logic [7:0]  mem [0:511];
  logic [8:0]  ram_addr_hi;

  int checks = 0;
  int errors = 0;
  int neg_cnt = 0;
  logic prev_done = 1'b0;

  logic [8:0]  exp_wa[$];
  logic [15:0] exp_wd[$];
  logic [8:0]  exp_ra[$];
  int          exp_done[$];

  ram16_copier #(.addrSize(9), .countSize(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .word_count   (word_count),
    .busy         (busy),
    .done         (done),
    .ram_addr     (ram_addr),
    .ram_data_out (ram_data_out),
    .ram_write_rq (ram_write_rq),
    .ram_output_en(ram_output_en),
    .ram_data_in  (ram_data_in)
  );

  always #5 clk = ~clk;

  // RAM model: little-endian word = {mem[a+1], mem[a]}, high byte wraps.
  assign ram_addr_hi = ram_addr + 9'd1;
  assign ram_data_in = ram_output_en ? {mem[ram_addr_hi], mem[ram_addr]} : 16'h0000;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr]        <= pl_data[7:0];
      mem[pl_addr + 9'd1] <= pl_data[15:8];
    end else if (ram_write_rq) begin
      mem[ram_addr]    <= ram_data_out[7:0];
      mem[ram_addr_hi] <= ram_data_out[15:8];
    end
  end

  // Monitor: compare every bus transaction and done pulse against the queues.
  always @(negedge clk) begin
    logic [8:0]  ea;
    logic [15:0] ed;
    int          ec;
    neg_cnt++;
    if (ram_write_rq) begin
      checks++;
      if (ram_output_en) begin
        errors++;
        $display("FAIL strobe_overlap: write_rq=1 output_en=1 at cycle %0d, required not both", neg_cnt);
      end
      if (exp_wa.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", ram_addr, ram_data_out);
      end else begin
        ea = exp_wa.pop_front();
        ed = exp_wd.pop_front();
        if (ram_addr !== ea || ram_data_out !== ed) begin
          errors++;
          $display("FAIL write: addr=%h data=%h, required addr=%h data=%h", ram_addr, ram_data_out, ea, ed);
        end else begin
          $display("write addr=%h data=%h", ram_addr, ram_data_out);
        end
      end
    end
    if (ram_output_en) begin
      checks++;
      if (exp_ra.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: addr=%h, required no read", ram_addr);
      end else begin
        ea = exp_ra.pop_front();
        if (ram_addr !== ea) begin
          errors++;
          $display("FAIL read: addr=%h, required addr=%h", ram_addr, ea);
        end else begin
          $display("read  addr=%h data=%h", ram_addr, ram_data_in);
        end
      end
    end
    if (done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width: done high for 2+ cycles at cycle %0d, required 1", neg_cnt);
      end
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: cycle %0d, required no done", neg_cnt);
      end else begin
        ec = exp_done.pop_front();
        if (neg_cnt != ec) begin
          errors++;
          $display("FAIL done_latency: done at cycle %0d, required cycle %0d", neg_cnt, ec);
        end else begin
          $display("done  cycle=%0d", neg_cnt);
        end
      end
    end
    prev_done = done;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_word(input string name, input logic [8:0] a, input logic [15:0] req);
    logic [8:0] hi;
    hi = a + 9'd1;
    chk(name, {16'h0, mem[hi], mem[a]}, {16'h0, req});
  endtask

  task automatic poke(input logic [8:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic ew(input logic [8:0] a, input logic [15:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
  endtask

  task automatic er(input logic [8:0] a);
    exp_ra.push_back(a);
  endtask

  // Pulse start for one edge; queue the done cycle (2*count+1 after the edge).
  task automatic launch(input logic [8:0] s, input logic [8:0] d, input logic [7:0] n,
                        input bit expect_done);
    @(posedge clk);
    #1;
    start = 1'b1;
    src_addr = s;
    dst_addr = d;
    word_count = n;
    @(posedge clk);
    if (expect_done) exp_done.push_back(neg_cnt + 2 * int'(n) + 1);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", {31'h0, busy}, 32'h1);
  endtask

  // Wait (bounded) for the queued done, then confirm the scoreboard drained.
  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (exp_done.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk({name, "_done_seen"}, exp_done.size(), 0);
    chk({name, "_writes_left"}, exp_wa.size(), 0);
    chk({name, "_reads_left"}, exp_ra.size(), 0);
    chk({name, "_busy_idle"}, {31'h0, busy}, 32'h0);
    exp_done.delete();
    exp_wa.delete();
    exp_wd.delete();
    exp_ra.delete();
  endtask

  localparam logic [15:0] WA = 16'hA0A1;
  localparam logic [15:0] WB = 16'hB0B1;
  localparam logic [15:0] WC = 16'hC0C1;
  localparam logic [15:0] WD = 16'hD0D1;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    word_count = '0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_ram_addr", {23'h0, ram_addr}, 32'h0);
    chk("rst_ram_data_out", {16'h0, ram_data_out}, 32'h0);
    chk("rst_strobes", {30'h0, ram_write_rq, ram_output_en}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Ascending copy 0x10 -> 0x40, three words
    poke(9'h010, 16'h1111);
    poke(9'h012, 16'h2222);
    poke(9'h014, 16'h3333);
    er(9'h010); ew(9'h040, 16'h1111);
    er(9'h012); ew(9'h042, 16'h2222);
    er(9'h014); ew(9'h044, 16'h3333);
    launch(9'h010, 9'h040, 8'd3, 1'b1);
    wait_idle("asc");
    chk_word("asc_dst0", 9'h040, 16'h1111);
    chk_word("asc_dst1", 9'h042, 16'h2222);
    chk_word("asc_dst2", 9'h044, 16'h3333);
    chk_word("asc_src0", 9'h010, 16'h1111);
    chk_word("asc_src2", 9'h014, 16'h3333);

    // Overlap with dst above src: must run top-down
    poke(9'h020, WA);
    poke(9'h022, WB);
    poke(9'h024, WC);
    poke(9'h026, WD);
    er(9'h026); ew(9'h028, WD);
    er(9'h024); ew(9'h026, WC);
    er(9'h022); ew(9'h024, WB);
    er(9'h020); ew(9'h022, WA);
    launch(9'h020, 9'h022, 8'd4, 1'b1);
    wait_idle("desc");
    chk_word("desc_0x22", 9'h022, WA);
    chk_word("desc_0x24", 9'h024, WB);
    chk_word("desc_0x26", 9'h026, WC);
    chk_word("desc_0x28", 9'h028, WD);

    // Overlap with dst below src: stays bottom-up (A..D now at 0x22..0x29)
    er(9'h022); ew(9'h020, WA);
    er(9'h024); ew(9'h022, WB);
    er(9'h026); ew(9'h024, WC);
    er(9'h028); ew(9'h026, WD);
    launch(9'h022, 9'h020, 8'd4, 1'b1);
    wait_idle("ovl_asc");
    chk_word("ovl_0x20", 9'h020, WA);
    chk_word("ovl_0x22", 9'h022, WB);
    chk_word("ovl_0x24", 9'h024, WC);
    chk_word("ovl_0x26", 9'h026, WD);

    // Zero count: done on the next cycle, no bus activity
    launch(9'h010, 9'h050, 8'd0, 1'b1);
    wait_idle("zero");

    // Start pulsed mid-copy is ignored
    poke(9'h180, 16'h7777);
    er(9'h010); ew(9'h060, 16'h1111);
    er(9'h012); ew(9'h062, 16'h2222);
    launch(9'h010, 9'h060, 8'd2, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1;
    src_addr = 9'h100;
    dst_addr = 9'h180;
    word_count = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("busy_start");
    chk_word("busy_start_dst0", 9'h060, 16'h1111);
    chk_word("busy_start_dst1", 9'h062, 16'h2222);
    chk_word("busy_start_untouched", 9'h180, 16'h7777);

    // Source pointer wraps past the top of memory
    poke(9'h1FC, 16'h5151);
    poke(9'h1FE, 16'h5252);
    poke(9'h000, 16'h5353);
    er(9'h1FC); ew(9'h080, 16'h5151);
    er(9'h1FE); ew(9'h082, 16'h5252);
    er(9'h000); ew(9'h084, 16'h5353);
    launch(9'h1FC, 9'h080, 8'd3, 1'b1);
    wait_idle("wrap");
    chk_word("wrap_dst0", 9'h080, 16'h5151);
    chk_word("wrap_dst1", 9'h082, 16'h5252);
    chk_word("wrap_dst2", 9'h084, 16'h5353);

    // Reset during the second WRITE: only the first word lands
    poke(9'h0A2, 16'hDEAD);
    poke(9'h0A4, 16'hBEEF);
    er(9'h1FC); ew(9'h0A0, 16'h5151);
    er(9'h1FE);
    launch(9'h1FC, 9'h0A0, 8'd3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_ram_addr", {23'h0, ram_addr}, 32'h0);
    chk("abort_ram_data_out", {16'h0, ram_data_out}, 32'h0);
    chk("abort_strobes", {30'h0, ram_write_rq, ram_output_en}, 32'h0);
    wait_idle("abort");
    chk_word("abort_dst0", 9'h0A0, 16'h5151);
    chk_word("abort_dst1", 9'h0A2, 16'hDEAD);
    chk_word("abort_dst2", 9'h0A4, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
